// File: rtl/dec_seq_nx.sv
// Registered N-to-2^N one-hot decoder with a stepping sequencer.
// The selected line walks through addresses in one-shot or circular mode.
module dec_seq_nx #(
    parameter  int N = 2,
    localparam int M = 2**N
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic         EN,
    input  logic [N-1:0] A,
    input  logic         LOAD,
    input  logic         STEP,
    input  logic         MODE,
    output logic [M-1:0] Y,
    output logic         ACT,
    output logic         DONE,
    output logic         WRAP
);

    localparam logic [N-1:0] LAST_PTR = N'(M - 1);

    logic [N-1:0] ptr_q, ptr_d;
    logic         act_q, act_d;
    logic [M-1:0] y_q, y_d;
    logic         done_q, done_d;
    logic         wrap_q, wrap_d;

    always_comb begin
        ptr_d  = ptr_q;
        act_d  = act_q;
        done_d = 1'b0;
        wrap_d = 1'b0;
        if (!EN) begin
            act_d = 1'b0;
        end else if (LOAD) begin
            ptr_d = A;
            act_d = 1'b1;
        end else if (STEP && act_q) begin
            if (MODE) begin
                ptr_d  = ptr_q + 1'b1;
                wrap_d = (ptr_q == LAST_PTR);
            end else if (ptr_q == LAST_PTR) begin
                act_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Y is decoded from the next state and stored, so the outputs never see a
    // combinational path and can only change as a single flop update.
    always_comb begin
        y_d = '0;
        for (int i = 0; i < M; i++) begin
            y_d[i] = act_d && (ptr_d == N'(i));
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            ptr_q  <= '0;
            act_q  <= 1'b0;
            y_q    <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            act_q  <= act_d;
            y_q    <= y_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    assign Y    = y_q;
    assign ACT  = act_q;
    assign DONE = done_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_dec_seq_nx.sv
// Self-checking bench for dec_seq_nx: directed vector table on N=2, hand-written
// corner sequences, and a randomised run on N=1,2,3,4 against a reference model.
module tb_dec_seq_nx;

    logic       clk;
    logic       rstb;
    logic       en, load, step, mode;
    logic [0:0] a1;
    logic [1:0] a2;
    logic [2:0] a3;
    logic [3:0] a4;

    logic [1:0]  y1;
    logic [3:0]  y2;
    logic [7:0]  y3;
    logic [15:0] y4;
    logic [3:0]  actV, doneV, wrapV;

    int nAsserts = 0;
    int nFail    = 0;

    dec_seq_nx #(.N(1)) d1 (.CLK(clk), .RSTB(rstb), .EN(en), .A(a1), .LOAD(load), .STEP(step),
                            .MODE(mode), .Y(y1), .ACT(actV[0]), .DONE(doneV[0]), .WRAP(wrapV[0]));
    dec_seq_nx #(.N(2)) d2 (.CLK(clk), .RSTB(rstb), .EN(en), .A(a2), .LOAD(load), .STEP(step),
                            .MODE(mode), .Y(y2), .ACT(actV[1]), .DONE(doneV[1]), .WRAP(wrapV[1]));
    dec_seq_nx #(.N(3)) d3 (.CLK(clk), .RSTB(rstb), .EN(en), .A(a3), .LOAD(load), .STEP(step),
                            .MODE(mode), .Y(y3), .ACT(actV[2]), .DONE(doneV[2]), .WRAP(wrapV[2]));
    dec_seq_nx #(.N(4)) d4 (.CLK(clk), .RSTB(rstb), .EN(en), .A(a4), .LOAD(load), .STEP(step),
                            .MODE(mode), .Y(y4), .ACT(actV[3]), .DONE(doneV[3]), .WRAP(wrapV[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one abstract scanner per instance, ptr kept as a plain integer.
    int modM[4] = '{2, 4, 8, 16};
    int mPtr[4];
    bit mAct[4], mDone[4], mWrap[4];
    int aVal[4];

    typedef struct {
        logic       en, load, step, mode;
        logic [1:0] a;
        logic [3:0] expY;
        logic       expAct, expDone, expWrap;
    } vec_t;
    vec_t vecs[$];

    task automatic addVec(input logic e, l, s, m, input logic [1:0] a,
                          input logic [3:0] y, input logic ac, dn, wr);
        vec_t v;
        v.en = e; v.load = l; v.step = s; v.mode = m; v.a = a;
        v.expY = y; v.expAct = ac; v.expDone = dn; v.expWrap = wr;
        vecs.push_back(v);
    endtask

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            mPtr[k] = 0; mAct[k] = 0; mDone[k] = 0; mWrap[k] = 0;
        end
    endtask

    task automatic modelEdge();
        for (int k = 0; k < 4; k++) begin
            mDone[k] = 0;
            mWrap[k] = 0;
            if (!en) begin
                mAct[k] = 0;
            end else if (load) begin
                mPtr[k] = aVal[k];
                mAct[k] = 1;
            end else if (step && mAct[k]) begin
                if (mPtr[k] + 1 < modM[k]) begin
                    mPtr[k] = mPtr[k] + 1;
                end else if (mode) begin
                    mPtr[k]  = 0;
                    mWrap[k] = 1;
                end else begin
                    mAct[k]  = 0;
                    mDone[k] = 1;
                end
            end
        end
    endtask

    // Drives one cycle of inputs after a falling edge, clocks it in, and
    // returns at the next falling edge where outputs are stable.
    task automatic applyStimulus(input logic e, l, s, m, input int av0, av1, av2, av3);
        en = e; load = l; step = s; mode = m;
        aVal[0] = av0; aVal[1] = av1; aVal[2] = av2; aVal[3] = av3;
        a1 = 1'(av0); a2 = 2'(av1); a3 = 3'(av2); a4 = 4'(av3);
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nAsserts++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    function automatic logic [63:0] dutY(input int k);
        case (k)
            0:       return 64'(y1);
            1:       return 64'(y2);
            2:       return 64'(y3);
            default: return 64'(y4);
        endcase
    endfunction

    task automatic checkAgainstModel(input int k);
        logic [63:0] expY;
        expY = mAct[k] ? (64'd1 << mPtr[k]) : 64'd0;
        checkOutput($sformatf("Y[N=%0d]", k + 1), dutY(k), expY);
        checkOutput($sformatf("ACT[N=%0d]", k + 1), 64'(actV[k]), 64'(mAct[k]));
        checkOutput($sformatf("DONE[N=%0d]", k + 1), 64'(doneV[k]), 64'(mDone[k]));
        checkOutput($sformatf("WRAP[N=%0d]", k + 1), 64'(wrapV[k]), 64'(mWrap[k]));
        checkOutput($sformatf("popcount[N=%0d]", k + 1), 64'($countones(dutY(k))), 64'(mAct[k]));
        checkOutput($sformatf("done_wrap_excl[N=%0d]", k + 1), 64'(doneV[k] & wrapV[k]), 64'd0);
    endtask

    task automatic checkD2(input string name, input logic [3:0] y, input logic ac, dn, wr);
        checkOutput({name, ".Y"}, 64'(y2), 64'(y));
        checkOutput({name, ".ACT"}, 64'(actV[1]), 64'(ac));
        checkOutput({name, ".DONE"}, 64'(doneV[1]), 64'(dn));
        checkOutput({name, ".WRAP"}, 64'(wrapV[1]), 64'(wr));
    endtask

    task automatic doReset();
        rstb = 1'b0;
        modelReset();
        @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
    endtask

    logic [7:0] circExp[4];

    initial begin
        rstb = 1'b0;
        en = 0; load = 0; step = 0; mode = 0;
        a1 = 0; a2 = 0; a3 = 0; a4 = 0;
        aVal = '{0, 0, 0, 0};
        modelReset();

        // Reset state
        @(posedge clk);
        @(negedge clk);
        checkD2("reset", 4'b0000, 0, 0, 0);
        rstb = 1'b1;

        // Directed N=2 vectors: en, load, step, mode, a, expY, act, done, wrap
        addVec(1, 1, 0, 0, 2, 4'b0100, 1, 0, 0);
        addVec(1, 1, 0, 0, 1, 4'b0010, 1, 0, 0);
        addVec(1, 0, 1, 0, 0, 4'b0100, 1, 0, 0);
        addVec(1, 0, 1, 0, 0, 4'b1000, 1, 0, 0);
        addVec(1, 0, 1, 0, 0, 4'b0000, 0, 1, 0);
        addVec(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
        addVec(1, 1, 1, 0, 3, 4'b1000, 1, 0, 0);
        addVec(0, 1, 0, 0, 1, 4'b0000, 0, 0, 0);
        addVec(1, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
        addVec(1, 1, 0, 1, 2, 4'b0100, 1, 0, 0);
        addVec(1, 0, 1, 1, 0, 4'b1000, 1, 0, 0);
        addVec(1, 0, 1, 1, 0, 4'b0001, 1, 0, 1);
        addVec(1, 0, 1, 1, 0, 4'b0010, 1, 0, 0);
        addVec(1, 0, 0, 1, 0, 4'b0010, 1, 0, 0);
        addVec(1, 0, 1, 0, 0, 4'b0100, 1, 0, 0);
        addVec(1, 0, 1, 0, 0, 4'b1000, 1, 0, 0);
        addVec(1, 0, 1, 1, 0, 4'b0001, 1, 0, 1);
        addVec(0, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 4'b0000, 0, 0, 0);
        addVec(1, 1, 0, 0, 3, 4'b1000, 1, 0, 0);
        addVec(1, 0, 1, 0, 0, 4'b0000, 0, 1, 0);
        addVec(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].load, vecs[i].step, vecs[i].mode,
                          0, int'(vecs[i].a), 0, 0);
            checkD2($sformatf("vec%0d", i), vecs[i].expY, vecs[i].expAct,
                    vecs[i].expDone, vecs[i].expWrap);
        end

        // Circular scan on N=3 starting at 6
        doReset();
        circExp = '{8'h40, 8'h80, 8'h01, 8'h02};
        applyStimulus(1, 1, 0, 1, 0, 0, 6, 0);
        checkOutput("circ3.load.Y", 64'(y3), 64'(circExp[0]));
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
            checkOutput($sformatf("circ3.step%0d.Y", i), 64'(y3), 64'(circExp[i]));
            checkOutput($sformatf("circ3.step%0d.WRAP", i), 64'(wrapV[2]), 64'(i == 2));
        end

        // Asynchronous reset in the middle of a circular scan on N=2
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
        checkD2("preRst", 4'b0010, 1, 0, 0);
        #2;
        rstb = 1'b0;
        modelReset();
        #1;
        checkD2("asyncRst", 4'b0000, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;
        applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
        checkD2("stepAfterRst", 4'b0000, 0, 0, 0);

        // Randomised run on all widths against the reference model
        doReset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic e, l, s, m;
            e = ($urandom_range(0, 19) != 0);
            l = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 9) < 7);
            m = (cyc % 500 < 250) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 19) != 0);
            applyStimulus(e, l, s, m,
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
            for (int k = 0; k < 4; k++) checkAgainstModel(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
